// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order FIFO of fetch_entry_t with flush; used for both the pending
// request metadata and the decode queue. DEPTH must be a power of 2, >= 2.
// An empty queue presents an all-zero head.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign valid   = (count != '0);
  assign do_pop  = pop && valid;
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = valid ? mem[rd_ptr] : '0;

  // Pointer and occupancy bookkeeping; flush empties the queue outright.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues imem requests under a credit
// limit, queues returned instructions for decode, and handles execute
// redirects by flushing and draining stale responses.
// Optional feature macro: FETCH_BP_EN (use bpHit/bpTarget for next PC).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] fetchPc,
  input  logic        bpHit,
  input  logic [31:0] bpTarget,
  output logic        imemReq,
  input  logic        imemReady,
  input  logic        imemRvalid,
  input  logic [31:0] imemRdata,
  input  logic        exRedirect,
  input  logic [31:0] exRedirectPc,
  output logic        decValid,
  input  logic        decReady,
  output logic [31:0] decInstr,
  output logic [31:0] decPc,
  output logic        decPredTaken,
  output logic [31:0] decPredTarget
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(QUEUE_DEPTH);

  fetch_state_t  state;
  fetch_state_t  state_next;
  logic [31:0]   pc_q;
  logic [31:0]   pc_seq;
  logic          pred_taken;
  logic [31:0]   pred_target;
  logic [CW-1:0] drop_count;
  logic [CW-1:0] drop_next;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] pend_count;
  logic [CW-1:0] dq_count;
  logic [CW:0]   in_flight;
  logic          credit_ok;
  logic          accept;
  logic          resp_keep;
  logic          dec_pop;
  logic          pend_valid;
  fetch_entry_t  pend_in;
  fetch_entry_t  pend_head;
  fetch_entry_t  dq_in;
  fetch_entry_t  dq_head;
  logic          unused_pend;

  assign fetchPc = pc_q;
  assign pc_seq  = pc_q + PC_STEP;

`ifdef FETCH_BP_EN
  assign pred_taken  = bpHit;
  assign pred_target = bpHit ? bpTarget : pc_seq;
`else
  logic unused_bp;
  assign unused_bp   = ^{bpHit, bpTarget};
  assign pred_taken  = 1'b0;
  assign pred_target = pc_seq;
`endif

  // Credit covers both requests in flight and entries awaiting decode.
  assign in_flight   = {1'b0, pend_count} + {1'b0, dq_count};
  assign credit_ok   = (in_flight < DEPTH_W);
  // The pending FIFO is flushed on entering DRAIN, so drop_count alone tracks it there.
  assign outstanding = (state == DRAIN) ? drop_count : pend_count;

  assign accept    = imemReq && imemReady;
  assign resp_keep = (state == FETCH) && imemRvalid && !exRedirect;
  assign dec_pop   = decValid && decReady && !exRedirect;

  // Next-state, request enable and drop accounting; redirect overrides all.
  always_comb begin
    state_next = state;
    drop_next  = drop_count;
    imemReq    = 1'b0;
    case (state)
      IDLE:  state_next = FETCH;
      FETCH: imemReq = credit_ok;
      DRAIN: begin
        if (imemRvalid) begin
          drop_next = drop_count - CW'(1);
          if (drop_count == CW'(1)) state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
    if (exRedirect) begin
      imemReq   = 1'b0;
      drop_next = (imemRvalid && (outstanding != '0)) ? outstanding - CW'(1) : outstanding;
      state_next = (drop_next != '0) ? DRAIN : FETCH;
    end
  end

  // State and drop counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      drop_count <= '0;
    end else begin
      state      <= state_next;
      drop_count <= drop_next;
    end
  end

  // Program counter: redirect wins, otherwise advance on each accepted request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else if (exRedirect) begin
      pc_q <= exRedirectPc;
    end else if (accept) begin
      pc_q <= pred_target;
    end
  end

  assign pend_in = '{instr: '0, pc: pc_q, pred_taken: pred_taken, pred_target: pred_target};

  fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_pending (
    .clk      (clk),
    .rst      (rst),
    .push     (accept),
    .push_data(pend_in),
    .pop      (resp_keep),
    .flush    (exRedirect),
    .head     (pend_head),
    .valid    (pend_valid),
    .count    (pend_count)
  );

  assign unused_pend = ^{pend_head.instr, pend_valid};

  assign dq_in = '{instr: imemRdata, pc: pend_head.pc,
                   pred_taken: pend_head.pred_taken, pred_target: pend_head.pred_target};

  fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_decode (
    .clk      (clk),
    .rst      (rst),
    .push     (resp_keep),
    .push_data(dq_in),
    .pop      (dec_pop),
    .flush    (exRedirect),
    .head     (dq_head),
    .valid    (decValid),
    .count    (dq_count)
  );

  assign decInstr      = dq_head.instr;
  assign decPc         = dq_head.pc;
  assign decPredTaken  = dq_head.pred_taken;
  assign decPredTarget = dq_head.pred_target;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that owns the program counter and drives it into the branch predictor. It consumes the predictor's same-cycle hit/target answer to choose the next PC, issues requests to instruction memory, and buffers returned instructions in a small in-order queue for decode. Execute-stage redirects override everything, flush the queue and discard stale memory responses.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded at reset.
- `QUEUE_DEPTH`, default 4: fetch queue entries; also the cap on outstanding requests. Must be a power of 2, ≥2.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `fetchPc`  out  32  current PC, to predictor and imem address.
- `bpHit`  in  1  predictor says `fetchPc` is a taken branch.
- `bpTarget`  in  32  predicted target.
- `imemReq`  out  1  request valid; address is `fetchPc`.
- `imemReady`  in  1  request accepted when `imemReq && imemReady`.
- `imemRvalid`  in  1  response valid; responses return in order, at least 1 cycle after acceptance.
- `imemRdata`  in  32  instruction word.
- `exRedirect`  in  1  mispredict/jump correction from execute.
- `exRedirectPc`  in  32  corrected PC.
- `decValid`  out  1  queue head valid.
- `decReady`  in  1  decode consumes head when `decValid && decReady`.
- `decInstr`  out  32  head instruction.
- `decPc`  out  32  head PC.
- `decPredTaken`  out  1  prediction used for head.
- `decPredTarget`  out  32  predicted next PC for head.

## Operation
- FSM states: `IDLE`, `FETCH`, `DRAIN`.
- `IDLE`: entered on reset; lasts one cycle, then `FETCH`. `imemReq`=0.
- `FETCH`: `imemReq`=1 while `outstanding + queueCount < QUEUE_DEPTH`. On acceptance, push a metadata record {pc, predTaken, predTarget} into a pending FIFO; `fetchPc` ← `bpHit ? bpTarget : fetchPc+4`. Wrap-around: 32-bit modulo, 0xFFFF_FFFC+4 = 0.
- Response in `FETCH`: pop the pending record and write {instr, pc, predTaken, predTarget} to the queue. Credit rule guarantees no overflow.
- `exRedirect` (any state, highest priority): `fetchPc` ← `exRedirectPc`; queue and pending FIFO flushed; no request issued that cycle. `dropCount` ← outstanding after this cycle (a same-cycle response is discarded and not counted). Next state is `DRAIN` if `dropCount`≠0, else `FETCH`.
- `DRAIN`: `imemReq`=0; each response decrements `dropCount` and is discarded; at 0 go to `FETCH`. A redirect in `DRAIN` updates `fetchPc` and keeps the current `dropCount` accounting.
- Simultaneous pop by decode and push by memory: both take effect; count unchanged.
- Decode pop on a redirect cycle is ignored (queue flushed).

## Timing
- Reset values: `fetchPc`=`RESET_PC`, `imemReq`=0, `decValid`=0, `dec*` data=0, counters 0, state `IDLE`.
- First request: cycle 2 after `rst` deasserts.
- Next-PC selection is registered: `bpHit` sampled in the acceptance cycle, new `fetchPc` visible the next cycle. Back-to-back issue is 1 request/cycle.
- Response-to-`decValid`: 1 cycle (registered queue write). Empty queue gives no bypass.
- Redirect-to-new-request: 1 cycle if nothing is outstanding, otherwise 1 cycle after the last stale response.

## Configuration
- `FETCH_BP_EN` defined: next PC uses `bpHit`/`bpTarget` as above.
- Undefined: `bpHit` and `bpTarget` are ignored. Next PC is always `fetchPc+4`; `decPredTaken`=0 and `decPredTarget`=`pc+4`. `fetchPc` is still driven.

## Structure
- `fetch_pkg`: `fetch_state_t` enum, `fetch_entry_t` struct {instr, pc, predTaken, predTarget}, `PC_STEP`=4.
- Sub-module `fetch_queue`: parameterised FIFO of `fetch_entry_t` with push, pop, flush, count. It is instantiated for both the pending-metadata FIFO and the decode queue.

## Test plan
- Reset: hold `rst`=0 for 3 cycles, then release. Expect `fetchPc`=0 and `imemReq`=0 for 1 cycle, then requests to 0x0, 0x4, 0x8 with `imemReady`=1.
- Predicted branch (`FETCH_BP_EN`): `bpHit`=1 with `bpTarget`=0x100 at PC 0x8. Next `fetchPc`=0x100; the decode entry for 0x8 has `decPredTaken`=1 and `decPredTarget`=0x100.
- Backpressure: `decReady`=0 with 2-cycle memory latency. Expect exactly 4 accepted requests, then `imemReq`=0 until decode pops. No entry is lost or duplicated.
- Redirect with 3 outstanding: `exRedirect` to 0x200. Expect the 3 following responses dropped, `decValid`=0 throughout, and the next request at 0x200.
- Redirect plus same-cycle response and decode pop: the response is discarded, the queue is empty next cycle, and `fetchPc`=`exRedirectPc`.
- Wrap: `exRedirectPc`=0xFFFF_FFFC gives a following request at 0x0.
